// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle 32-bit shifter controller. Accepts one SLL/SRA request, then
// walks the power-of-two stages 16, 8, 4, 2, 1 (one per clock), applying a
// stage only when the matching shamt bit is set. The result is held on a
// valid/ready output until the consumer takes it.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid and ready are both high. The producer keeps valid and its
// payload stable until that edge. in_ready, out_valid, busy and data_out
// are registered and never depend combinationally on inputs.
//
// Parameters:
//   EARLY_DONE  0: fixed 5-cycle latency
//               1: finish once all remaining lower shamt bits are zero
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   in_valid   in   request present
//   in_ready   out  sequencer can accept a request (IDLE)
//   data_in    in   32-bit operand
//   shamt      in   5-bit shift amount
//   shift_op   in   0 = SLL (zero fill), 1 = SRA (sign fill)
//   out_valid  out  result available (DONE)
//   out_ready  in   consumer takes the result
//   data_out   out  shift result (the work register)
//   busy       out  high in SHIFT or DONE
//   dbg_state  out  current FSM state, for observation only
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter bit EARLY_DONE = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic        shift_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] work;
    logic [4:0]  sh_q;
    logic        op_q;
    logic [2:0]  stage;

    // One-hot weight of the current stage (stage 4 -> 16 ... stage 0 -> 1).
    logic [4:0]  stage_bit;
    logic [4:0]  lower_mask;
    logic        apply;
    logic        lower_zero;
    logic        last_stage;
    logic [31:0] shifted;
    logic [31:0] next_work;

    always_comb begin
        stage_bit  = 5'd1 << stage;
        lower_mask = stage_bit - 5'd1;
        apply      = |(sh_q & stage_bit);
        // For stage 0 the mask is empty, so this is always true.
        lower_zero = ((sh_q & lower_mask) == 5'd0);
        last_stage = (stage == 3'd0) || (EARLY_DONE && lower_zero);
        // The sign bit survives every arithmetic stage, so chaining stages
        // gives the same result as one arithmetic shift of the operand.
        if (op_q)
            shifted = $signed(work) >>> stage_bit;
        else
            shifted = work << stage_bit;
        next_work = apply ? shifted : work;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            work      <= 32'd0;
            sh_q      <= 5'd0;
            op_q      <= 1'b0;
            stage     <= 3'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= data_in;
                        sh_q     <= shamt;
                        op_q     <= shift_op;
                        stage    <= 3'd4;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    work <= next_work;
                    if (last_stage) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        stage <= stage - 3'd1;
                    end
                end
                DONE: begin
                    // in_ready rises at this edge, so a new request can only
                    // be accepted on the following edge.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = work;
    assign dbg_state = state;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller for the processor's 32-bit shift datapath. It accepts one shift request (SLL or SRA, shamt 0..31) over a valid/ready handshake. It then applies the fixed power-of-two shift stages (16, 8, 4, 2, 1) one per cycle, gated by the shamt bits. The result is held on a valid/ready output until consumed, so one stage set is shared in time instead of a full combinational barrel shifter, and the ALU can stall on it.

Parameters:
EARLY_DONE, 0, 1 = finish as soon as all remaining lower shamt bits are zero; 0 = fixed 5-cycle latency.

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  request present
in_ready  output  1  sequencer can accept a request
data_in  input  32  operand
shamt  input  5  shift amount
shift_op  input  1  0 = SLL (zero fill), 1 = SRA (sign fill from bit 31)
out_valid  output  1  result available
out_ready  input  1  consumer takes result
data_out  output  32  shift result
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (reset low, asynchronous): state = IDLE, data_out = 0, out_valid = 0, in_ready = 1, busy = 0, internal shamt/op/stage registers = 0. Reset mid-operation aborts the operation with no output produced.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from state only; no input-to-output combinational path.
- IDLE: in_ready = 1. On an edge with in_valid = 1, latch data_in into the work register, latch shamt and shift_op, set stage = 4, go to SHIFT.
- SHIFT: in_ready = 0. Each edge applies stage k (shift of 2^k) if the latched shamt[k] = 1, otherwise passes the value through.
  - SLL: zeros enter at LSB.
  - SRA: copies of the work register's bit 31 enter at MSB. Because the sign is preserved through each stage, this equals an arithmetic shift of the original operand.
  - stage decrements by 1 each edge.
  - Go to DONE after stage 0, or, when EARLY_DONE = 1, after any stage k where shamt[k-1:0] = 0 (for k = 0 this is always true).
- DONE: out_valid = 1, data_out = work register, held stable while out_ready = 0. On an edge with out_ready = 1: out_valid goes to 0 and the state goes to IDLE. in_ready returns to 1 on the following cycle (no same-cycle re-accept).
- Latency, measured from the accepting edge to the edge where out_valid rises:
  - EARLY_DONE = 0: exactly 5.
  - EARLY_DONE = 1: 5 minus the number of trailing zero bits of shamt, minimum 1 (shamt = 0 gives 1).
- in_valid while busy is ignored; the request is not captured and the requester must hold it until in_ready = 1.
- data_in, shamt and shift_op changing after acceptance have no effect.
- shamt = 0 returns data_in unchanged for both ops.
- Throughput is at most one operation per (latency + 2) cycles.
- Widths are fixed at 32/5. There is no overflow detection; bits shifted out are discarded.

Test Plan:
- SLL: data_in = 0x0000_FFFF, shamt = 16, EARLY_DONE = 0, out_ready = 1 -> data_out = 0xFFFF_0000, out_valid rises 5 edges after accept and stays high for 1 cycle, in_ready = 1 one cycle later.
- SRA: 0x8000_0000 by 31 -> 0xFFFF_FFFF. SRA 0x7000_0000 by 4 -> 0x0700_0000. SLL 0x0000_0001 by 31 -> 0x8000_0000.
- shamt = 0 with data_in = 0xDEAD_BEEF, both ops -> data_out = 0xDEAD_BEEF. Latency 5 with EARLY_DONE = 0, latency 1 with EARLY_DONE = 1.
- Backpressure: hold out_ready = 0 for 3 cycles after out_valid, and pulse in_valid with a new operand during that window -> data_out stable, out_valid held, in_ready = 0, new request not captured. When out_ready = 1, the next request is accepted only after in_ready rises.
- Reset mid-operation: assert reset low 2 edges after accept -> immediately out_valid = 0, data_out = 0, in_ready = 1, state IDLE. After release, a fresh SLL 0x1 by 1 yields 0x2.
- EARLY_DONE = 1: shamt = 16 -> latency 1. shamt = 8 -> latency 2. shamt = 1 -> latency 5. SRA 0xF000_0000 by 12 -> 0xFFFF_0000 at latency 3.
